// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 master bridge.
// Holds the bus-cycle state encoding and the PPROT attribute bit positions.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  // PPROT[0]: privileged, PPROT[1]: non-secure, PPROT[2]: instruction fetch
  localparam logic [2:0] PROT_PRIVILEGED  = 3'b001;
  localparam logic [2:0] PROT_NONSECURE   = 3'b010;
  localparam logic [2:0] PROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/apb_bus.sv
// APB4 master bridge: turns a local request plus Transfer strobe into SETUP/ACCESS
// bus cycles and returns read data and slave-error status of the last completion.
module apb_bus
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int SLAVES_NUM   = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   ADDR_in,
  input  logic [DATA_WIDTH-1:0]   DATA_in,
  input  logic [2:0]              PROT_in,
  input  logic [SLAVES_NUM-1:0]   SEL_in,
  input  logic [STROBE_WIDTH-1:0] STROB_in,
  input  logic                    WRITE_in,
  input  logic                    Transfer,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  output logic [DATA_WIDTH-1:0]   DATA_out,
  output logic                    SLVERR_out,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [STROBE_WIDTH-1:0] PSTRB,
  output logic [2:0]              PPROT,
  output logic [SLAVES_NUM-1:0]   PSEL,
  output logic                    PENABLE
);

  apb_state_e state_reg, state_next;

  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [2:0]              prot_reg;
  logic [SLAVES_NUM-1:0]   sel_reg;
  logic [STROBE_WIDTH-1:0] strb_reg;
  logic                    write_reg;

  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic                    slverr_reg;

  logic req_valid;
  logic complete;
  logic capture_en;

  assign req_valid  = Transfer && (SEL_in != '0);
  assign complete   = (state_reg == ACCESS) && PREADY;
  // Capture happens on exactly the edges that land in SETUP.
  assign capture_en = req_valid && ((state_reg == IDLE) || complete);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    PSEL       = '0;
    PENABLE    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        PSEL       = sel_reg;
        state_next = ACCESS;
      end
      ACCESS: begin
        PSEL    = sel_reg;
        PENABLE = 1'b1;
        if (PREADY) begin
          state_next = req_valid ? SETUP : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_reg  <= '0;
      data_reg  <= '0;
      prot_reg  <= '0;
      sel_reg   <= '0;
      strb_reg  <= '0;
      write_reg <= 1'b0;
    end else if (capture_en) begin
      addr_reg  <= ADDR_in;
      data_reg  <= DATA_in;
      prot_reg  <= PROT_in;
      sel_reg   <= SEL_in;
      strb_reg  <= STROB_in;
      write_reg <= WRITE_in;
    end
  end

  // Completion results persist until the next completion; writes keep old read data.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdata_reg  <= '0;
      slverr_reg <= 1'b0;
    end else if (complete) begin
      slverr_reg <= PSLVERR;
      if (!write_reg) begin
        rdata_reg <= PRDATA;
      end
    end
  end

  assign PADDR      = addr_reg;
  assign PWRITE     = write_reg;
  assign PPROT      = prot_reg;
  assign PWDATA     = write_reg ? data_reg : '0;
  assign PSTRB      = write_reg ? strb_reg : '0;
  assign DATA_out   = rdata_reg;
  assign SLVERR_out = slverr_reg;

endmodule

// File: tb/tb_apb_bus.sv
// Directed bench for apb_bus: a per-cycle vector table for the main sequence,
// plus a hand-written asynchronous reset during a stalled ACCESS.
module tb_apb_bus;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] ADDR_in, DATA_in, PRDATA;
  logic [2:0]  PROT_in;
  logic [1:0]  SEL_in;
  logic [3:0]  STROB_in;
  logic        WRITE_in, Transfer, PREADY, PSLVERR;
  logic [31:0] DATA_out, PADDR, PWDATA;
  logic        SLVERR_out, PWRITE, PENABLE;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [1:0]  PSEL;

  int checks = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  apb_bus #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .STROBE_WIDTH(4), .SLAVES_NUM(2)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .ADDR_in(ADDR_in), .DATA_in(DATA_in),
    .PROT_in(PROT_in), .SEL_in(SEL_in), .STROB_in(STROB_in), .WRITE_in(WRITE_in),
    .Transfer(Transfer), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .DATA_out(DATA_out), .SLVERR_out(SLVERR_out), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE)
  );

  typedef struct {
    logic        tr;
    logic [1:0]  sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  prot;
    logic [3:0]  strb;
    logic [31:0] prdata;
    logic        rdy;
    logic        err;
    logic [1:0]  e_psel;
    logic        e_pen;
    logic        e_pwr;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic [2:0]  e_pprot;
    logic [3:0]  e_pstrb;
    logic [31:0] e_dout;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  function automatic vec_t mk(
    logic tr, logic [1:0] sel, logic wr, logic [31:0] addr, logic [31:0] data,
    logic [2:0] prot, logic [3:0] strb, logic [31:0] prdata, logic rdy, logic err,
    logic [1:0] e_psel, logic e_pen, logic e_pwr, logic [31:0] e_paddr,
    logic [31:0] e_pwdata, logic [2:0] e_pprot, logic [3:0] e_pstrb,
    logic [31:0] e_dout, logic e_err);
    vec_t v;
    v.tr = tr; v.sel = sel; v.wr = wr; v.addr = addr; v.data = data;
    v.prot = prot; v.strb = strb; v.prdata = prdata; v.rdy = rdy; v.err = err;
    v.e_psel = e_psel; v.e_pen = e_pen; v.e_pwr = e_pwr; v.e_paddr = e_paddr;
    v.e_pwdata = e_pwdata; v.e_pprot = e_pprot; v.e_pstrb = e_pstrb;
    v.e_dout = e_dout; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"},   {30'd0, PSEL}, 32'd0);
    chk({tag, "_penable"}, {31'd0, PENABLE}, 32'd0);
    chk({tag, "_pwrite"}, {31'd0, PWRITE}, 32'd0);
    chk({tag, "_paddr"},  PADDR, 32'd0);
    chk({tag, "_pwdata"}, PWDATA, 32'd0);
    chk({tag, "_pstrb"},  {28'd0, PSTRB}, 32'd0);
    chk({tag, "_pprot"},  {29'd0, PPROT}, 32'd0);
    chk({tag, "_data_out"}, DATA_out, 32'd0);
    chk({tag, "_slverr"}, {31'd0, SLVERR_out}, 32'd0);
  endtask

  initial begin
    // tr sel wr addr data prot strb prdata rdy err | psel pen pwr paddr pwdata pprot pstrb dout err
    // Read to slave 0 with PREADY high: SETUP/ACCESS alternate back to back.
    tbl[0]  = mk(1, 2'b01, 0, 32'h20, 32'h0,  3'd1, 4'h0, 32'd500, 1, 0,  2'b01, 0, 0, 32'h20, 32'h0,  3'd1, 4'h0, 32'd0,   0);
    tbl[1]  = mk(1, 2'b01, 0, 32'h20, 32'h0,  3'd1, 4'h0, 32'd500, 1, 0,  2'b01, 1, 0, 32'h20, 32'h0,  3'd1, 4'h0, 32'd0,   0);
    tbl[2]  = mk(1, 2'b01, 0, 32'h20, 32'h0,  3'd1, 4'h0, 32'd500, 1, 0,  2'b01, 0, 0, 32'h20, 32'h0,  3'd1, 4'h0, 32'd500, 0);
    tbl[3]  = mk(1, 2'b01, 0, 32'h20, 32'h0,  3'd1, 4'h0, 32'd500, 1, 0,  2'b01, 1, 0, 32'h20, 32'h0,  3'd1, 4'h0, 32'd500, 0);
    // Read completes with 600 while a write to 0x10 is captured.
    tbl[4]  = mk(1, 2'b01, 1, 32'h10, 32'd10, 3'd2, 4'hF, 32'd600, 1, 0,  2'b01, 0, 1, 32'h10, 32'd10, 3'd2, 4'hF, 32'd600, 0);
    // Local inputs change in SETUP; PSLVERR high outside completion is ignored.
    tbl[5]  = mk(1, 2'b10, 1, 32'h44, 32'h55, 3'd7, 4'h3, 32'h0,   1, 1,  2'b01, 1, 1, 32'h10, 32'd10, 3'd2, 4'hF, 32'd600, 0);
    // Write completes with error; DATA_out kept; read to slave 1 captured.
    tbl[6]  = mk(1, 2'b10, 0, 32'h30, 32'h77, 3'd5, 4'hF, 32'hDEAD, 1, 1, 2'b10, 0, 0, 32'h30, 32'h0,  3'd5, 4'h0, 32'd600, 1);
    // Transfer dropped; three wait states in ACCESS.
    tbl[7]  = mk(0, 2'b00, 1, 32'h99, 32'h99, 3'd0, 4'hF, 32'h0,   0, 0,  2'b10, 1, 0, 32'h30, 32'h0,  3'd5, 4'h0, 32'd600, 1);
    tbl[8]  = mk(0, 2'b00, 1, 32'h99, 32'h99, 3'd0, 4'hF, 32'h111, 0, 0,  2'b10, 1, 0, 32'h30, 32'h0,  3'd5, 4'h0, 32'd600, 1);
    tbl[9]  = mk(0, 2'b00, 1, 32'h99, 32'h99, 3'd0, 4'hF, 32'h111, 0, 0,  2'b10, 1, 0, 32'h30, 32'h0,  3'd5, 4'h0, 32'd600, 1);
    tbl[10] = mk(0, 2'b00, 1, 32'h99, 32'h99, 3'd0, 4'hF, 32'h111, 0, 0,  2'b10, 1, 0, 32'h30, 32'h0,  3'd5, 4'h0, 32'd600, 1);
    // Completion without error, back to IDLE.
    tbl[11] = mk(0, 2'b00, 0, 32'h0,  32'h0,  3'd0, 4'h0, 32'h1234, 1, 0, 2'b00, 0, 0, 32'h30, 32'h0,  3'd5, 4'h0, 32'h1234, 0);
    // No valid request: SEL_in zero, then Transfer low.
    tbl[12] = mk(1, 2'b00, 0, 32'h50, 32'h0,  3'd0, 4'h0, 32'h0,   1, 1,  2'b00, 0, 0, 32'h30, 32'h0,  3'd5, 4'h0, 32'h1234, 0);
    tbl[13] = mk(0, 2'b01, 0, 32'h50, 32'h0,  3'd0, 4'h0, 32'h0,   1, 1,  2'b00, 0, 0, 32'h30, 32'h0,  3'd5, 4'h0, 32'h1234, 0);

    PRESETn = 1'b0;
    Transfer = 0; SEL_in = 0; WRITE_in = 0; ADDR_in = 0; DATA_in = 0;
    PROT_in = 0; STROB_in = 0; PRDATA = 0; PREADY = 0; PSLVERR = 0;
    repeat (2) @(negedge PCLK);
    chk_all_zero("reset");

    for (int i = 0; i < NVEC; i++) begin
      @(negedge PCLK);
      PRESETn  = 1'b1;
      Transfer = tbl[i].tr;   SEL_in  = tbl[i].sel;  WRITE_in = tbl[i].wr;
      ADDR_in  = tbl[i].addr; DATA_in = tbl[i].data; PROT_in  = tbl[i].prot;
      STROB_in = tbl[i].strb; PRDATA  = tbl[i].prdata;
      PREADY   = tbl[i].rdy;  PSLVERR = tbl[i].err;
      @(posedge PCLK);
      #1;
      $display("vec %0d: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h pprot=%0d dout=%h err=%b",
               i, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, DATA_out, SLVERR_out);
      chk($sformatf("v%0d_psel", i),    {30'd0, PSEL},      {30'd0, tbl[i].e_psel});
      chk($sformatf("v%0d_penable", i), {31'd0, PENABLE},   {31'd0, tbl[i].e_pen});
      chk($sformatf("v%0d_pwrite", i),  {31'd0, PWRITE},    {31'd0, tbl[i].e_pwr});
      chk($sformatf("v%0d_paddr", i),   PADDR,              tbl[i].e_paddr);
      chk($sformatf("v%0d_pwdata", i),  PWDATA,             tbl[i].e_pwdata);
      chk($sformatf("v%0d_pstrb", i),   {28'd0, PSTRB},     {28'd0, tbl[i].e_pstrb});
      chk($sformatf("v%0d_pprot", i),   {29'd0, PPROT},     {29'd0, tbl[i].e_pprot});
      chk($sformatf("v%0d_data_out", i), DATA_out,          tbl[i].e_dout);
      chk($sformatf("v%0d_slverr", i),  {31'd0, SLVERR_out}, {31'd0, tbl[i].e_err});
    end

    // Stalled write, then asynchronous reset in the middle of ACCESS.
    @(negedge PCLK);
    Transfer = 1; SEL_in = 2'b01; WRITE_in = 1; ADDR_in = 32'h60; DATA_in = 32'hAB;
    PROT_in = 3'd3; STROB_in = 4'h5; PREADY = 0; PSLVERR = 1;
    @(negedge PCLK);
    Transfer = 0;
    @(posedge PCLK);
    #1;
    $display("rst_seq: in ACCESS psel=%b pen=%b paddr=%h", PSEL, PENABLE, PADDR);
    chk("rst_seq_penable", {31'd0, PENABLE}, 32'd1);
    chk("rst_seq_paddr", PADDR, 32'h60);
    chk("rst_seq_pwdata", PWDATA, 32'hAB);
    chk("rst_seq_dout_before", DATA_out, 32'h1234);
    #2;
    PRESETn = 1'b0;
    #1;
    $display("rst_seq: async reset psel=%b pen=%b dout=%h", PSEL, PENABLE, DATA_out);
    chk_all_zero("async_rst");
    @(negedge PCLK);
    PREADY = 1;
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    $display("rst_seq: after release psel=%b pen=%b dout=%h err=%b", PSEL, PENABLE, DATA_out, SLVERR_out);
    chk("post_rst_psel", {30'd0, PSEL}, 32'd0);
    chk("post_rst_dout", DATA_out, 32'd0);
    chk("post_rst_slverr", {31'd0, SLVERR_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
